// File: rtl/fir_pkg.sv
// Shared widths, tap constants, FSM state codes and coefficient ROM for the
// pulse-sensor FIR MAC scheduler.
package fir_pkg;

   localparam int unsigned DATA_W  = 10;
   localparam int unsigned COEFF_W = 7;
   localparam int unsigned ACC_W   = 21;
   localparam int unsigned SHIFT   = 10;
   localparam int unsigned NTAPS   = 31;
   localparam int unsigned NHALF   = 16;
   localparam int unsigned K_W     = 4;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned PRE_W   = DATA_W + 1;
   localparam int unsigned PROD_W  = PRE_W + COEFF_W;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   // Mirrored tap pair read from the delay line for one MAC step
   typedef struct packed {
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] hi;
   } tap_pair_t;

   // Half of the symmetric low-pass kernel, in units of 1/1024; index 15 is the centre tap
   function automatic logic [COEFF_W-1:0] coeff(input logic [K_W-1:0] k);
      case (k)
         4'd0:    coeff = 7'd3;
         4'd1:    coeff = 7'd4;
         4'd2:    coeff = 7'd6;
         4'd3:    coeff = 7'd8;
         4'd4:    coeff = 7'd12;
         4'd5:    coeff = 7'd17;
         4'd6:    coeff = 7'd23;
         4'd7:    coeff = 7'd29;
         4'd8:    coeff = 7'd36;
         4'd9:    coeff = 7'd43;
         4'd10:   coeff = 7'd50;
         4'd11:   coeff = 7'd56;
         4'd12:   coeff = 7'd61;
         4'd13:   coeff = 7'd65;
         4'd14:   coeff = 7'd67;
         default: coeff = 7'd68;
      endcase
   endfunction

endpackage

// File: rtl/fir_tap_line.sv
// 31-entry sample delay line with two combinational read ports at mirrored taps k and 30-k.
module fir_tap_line
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [K_W-1:0]    k,
   output tap_pair_t         taps_c
);

   logic [DATA_W-1:0] v [NTAPS];
   logic [IDX_W-1:0]  idx_lo_c;
   logic [IDX_W-1:0]  idx_hi_c;

   // Shift toward v[0]; the newest sample lands in v[30]
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NTAPS); i++) begin
            v[i] <= '0;
         end
      end else if (shift_en) begin
         for (int i = 0; i < int'(NTAPS) - 1; i++) begin
            v[i] <= v[i+1];
         end
         v[NTAPS-1] <= sample_in;
      end
   end

   // Mirrored tap selection for the pre-adder
   always_comb begin
      idx_lo_c  = {1'b0, k};
      idx_hi_c  = IDX_W'(NTAPS - 1) - {1'b0, k};
      taps_c.lo = v[idx_lo_c];
      taps_c.hi = v[idx_hi_c];
   end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed 31-tap symmetric FIR: one sample in, 16 shared-multiplier MAC steps,
// one saturated sample out. Define FIR_ROUND_EN for round-half-up output scaling;
// otherwise the accumulator is truncated.
module fir_mac_scheduler
   import fir_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   output logic              sample_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              overrun,
   input  logic              overrun_clr
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [K_W-1:0]    k;
   logic [K_W-1:0]    k_nxt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_nxt;
   logic [DATA_W-1:0] out_data_nxt;
   logic              out_valid_nxt;
   logic              overrun_nxt;
   logic              shift_en_c;
   tap_pair_t         taps_c;
   logic [PRE_W-1:0]  pre_c;
   logic [PROD_W-1:0] prod_c;
   logic [ACC_W-1:0]  biased_c;
   logic [ACC_W-1:0]  scaled_c;
   logic [DATA_W-1:0] sat_c;

   fir_tap_line u_tap_line (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (shift_en_c),
      .sample_in (sample_in),
      .k         (k),
      .taps_c    (taps_c)
   );

   // Pre-add mirrored taps (centre tap alone) and feed the single shared multiplier
   always_comb begin
      if (k == K_W'(NHALF - 1)) begin
         pre_c = PRE_W'(taps_c.lo);
      end else begin
         pre_c = PRE_W'(taps_c.lo) + PRE_W'(taps_c.hi);
      end
      prod_c = PROD_W'(pre_c) * PROD_W'(coeff(k));
   end

   // Output scaling and saturation to the sample range
   always_comb begin
`ifdef FIR_ROUND_EN
      biased_c = acc + ACC_W'(1 << (SHIFT - 1));
`else
      biased_c = acc;
`endif
      scaled_c = biased_c >> SHIFT;
      sat_c    = (|scaled_c[ACC_W-1:DATA_W]) ? '1 : scaled_c[DATA_W-1:0];
   end

   // Next-state and datapath control for IDLE -> MAC x16 -> OUT -> IDLE
   always_comb begin
      state_nxt     = state;
      k_nxt         = k;
      acc_nxt       = acc;
      out_data_nxt  = out_data;
      out_valid_nxt = 1'b0;
      shift_en_c    = 1'b0;
      overrun_nxt   = overrun & ~overrun_clr;
      case (state)
         IDLE: begin
            if (sample_valid) begin
               shift_en_c = 1'b1;
               acc_nxt    = '0;
               k_nxt      = '0;
               state_nxt  = MAC;
            end
         end
         MAC: begin
            acc_nxt = acc + ACC_W'(prod_c);
            k_nxt   = k + K_W'(1);
            if (k == K_W'(NHALF - 1)) begin
               state_nxt = OUT;
            end
            if (sample_valid) begin
               overrun_nxt = 1'b1;
            end
         end
         OUT: begin
            out_data_nxt  = sat_c;
            out_valid_nxt = 1'b1;
            state_nxt     = IDLE;
            if (sample_valid) begin
               overrun_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         k            <= '0;
         acc          <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         overrun      <= 1'b0;
         sample_ready <= 1'b1;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         k            <= k_nxt;
         acc          <= acc_nxt;
         out_data     <= out_data_nxt;
         out_valid    <= out_valid_nxt;
         overrun      <= overrun_nxt;
         sample_ready <= (state_nxt == IDLE);
         busy         <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: stimulus pushes expected results, a negedge
// monitor pops and compares on every out_valid pulse.
module tb_fir_mac_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_valid;
   logic [9:0] sample_in;
   logic       sample_ready;
   logic       out_valid;
   logic [9:0] out_data;
   logic       busy;
   logic       overrun;
   logic       overrun_clr;

   int checks   = 0;
   int failures = 0;
   int ecount   = 0;

`ifdef FIR_ROUND_EN
   localparam int IMP_EXP = 3;
`else
   localparam int IMP_EXP = 2;
`endif

   typedef struct {
      int data;
      int acc_edge;
   } exp_t;

   exp_t q[$];
   int   mv[31];
   int   coef_tb[16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};

   fir_mac_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .sample_ready (sample_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .busy         (busy),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, ecount);
      end
   endtask

   // Full 31-tap convolution over the model delay line
   function automatic int model_out();
      int unsigned a;
      a = 0;
      for (int i = 0; i < 31; i++) begin
         a += int'(coef_tb[(i < 16) ? i : 30 - i] * mv[i]);
      end
`ifdef FIR_ROUND_EN
      a += 512;
`endif
      a = a >> 10;
      return (a > 1023) ? 1023 : int'(a);
   endfunction

   task automatic model_accept(input int s);
      exp_t e;
      for (int i = 0; i < 30; i++) mv[i] = mv[i+1];
      mv[30] = s;
      e.data = model_out();
      e.acc_edge = ecount;
      q.push_back(e);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 31; i++) mv[i] = 0;
      q.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int s);
      int n;
      n = 0;
      while (!sample_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!sample_ready) begin
         failures++;
         $display("FAIL send_ready_timeout sample_ready=0 required=1 after %0d cycles", n);
         $fatal(1, "sample_ready never returned");
      end
      sample_valid = 1'b1;
      sample_in    = 10'(s);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      model_accept(s);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: every out_valid pulse must match the oldest pending expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid out_data=%0d required=no pulse", out_data);
         end else begin
            e = q.pop_front();
            chk("out_data", int'(out_data), e.data);
            chk("latency", ecount - e.acc_edge, 17);
         end
      end
   end

   initial begin
      int ph;
      int exp_rdy;
      int exp_ovr;
      int take;
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      overrun_clr  = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_sample_ready", int'(sample_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);

      // Impulse
      send(1023);
      drain();
      chk("impulse_first", int'(out_data), IMP_EXP);
      for (int i = 0; i < 5; i++) send(0);
      drain();

      // Step to 512
      repeat (31) send(512);
      drain();
      chk("step_512", int'(out_data), 514);

      // Saturation
      repeat (31) send(1023);
      drain();
      chk("saturate", int'(out_data), 1023);

      // Back-to-back with sample_valid held high
      chk("ovr_before_b2b", int'(overrun), 0);
      sample_valid = 1'b1;
      ph      = 0;
      exp_ovr = 0;
      for (int c = 0; c < 76; c++) begin
         sample_in = 10'((c * 37) % 1024);
         exp_rdy = (ph == 0 || ph >= 18) ? 1 : 0;
         chk("b2b_ready", int'(sample_ready), exp_rdy);
         chk("b2b_busy", int'(busy), 1 - exp_rdy);
         chk("b2b_overrun", int'(overrun), exp_ovr);
         take = exp_rdy;
         @(posedge clk);
         #1;
         if (take != 0) begin
            model_accept(int'(sample_in));
            ph = 1;
         end else begin
            exp_ovr = 1;
            ph++;
         end
      end
      sample_valid = 1'b0;
      drain();
      chk("ovr_sticky", int'(overrun), 1);
      overrun_clr = 1'b1;
      @(posedge clk);
      #1;
      overrun_clr = 1'b0;
      chk("ovr_clear", int'(overrun), 0);

      // Clear and drop in the same cycle: set wins, delay line untouched
      send(300);
      sample_valid = 1'b1;
      sample_in    = 10'd777;
      overrun_clr  = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      overrun_clr  = 1'b0;
      chk("ovr_set_wins", int'(overrun), 1);
      drain();
      send(5);
      drain();

      // Reset at k=8 abandons the computation
      send(700);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_ready", int'(sample_ready), 1);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_overrun", int'(overrun), 0);
      repeat (30) @(posedge clk);
      #1;
      send(1023);
      drain();
      chk("post_rst_impulse", int'(out_data), IMP_EXP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
